// File: rtl/sim_finish_controller.sv
// End-of-test controller: N finish/error sources, masking, all-of/any-of completion, watchdog,
// drain window and registered verdict. Define SIM_FINISH_EN to end simulation once done is seen.
module sim_finish_controller #(
    parameter int unsigned NUM_SOURCES    = 2,
    parameter int unsigned REQUIRE_ALL    = 1,
    parameter int unsigned DRAIN_CYCLES   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic [NUM_SOURCES-1:0] src_mask,
    input  logic [NUM_SOURCES-1:0] finish_req,
    input  logic [NUM_SOURCES-1:0] error_req,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   fail,
    output logic                   timeout,
    output logic [NUM_SOURCES-1:0] seen_finish,
    output logic [NUM_SOURCES-1:0] seen_error,
    output logic [CNT_W-1:0]       cycle_count
);

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

    state_e                 state_q, state_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic                   fail_q, fail_d;
    logic                   timeout_q, timeout_d;
    logic [NUM_SOURCES-1:0] seen_finish_q, seen_finish_d;
    logic [NUM_SOURCES-1:0] seen_error_q, seen_error_d;
    logic [CNT_W-1:0]       cycle_count_q, cycle_count_d;
    logic [DRAIN_W-1:0]     drain_cnt_q, drain_cnt_d;

    logic [NUM_SOURCES-1:0] nf, ne;
    logic                   fin_ok, err_hit;

    // Completion looks at the latch values this edge will produce, so a single-cycle
    // pulse completes on the edge that samples it.
    always_comb begin
        nf      = seen_finish_q | finish_req;
        ne      = seen_error_q | error_req;
        fin_ok  = (REQUIRE_ALL != 0) ? ((&(nf | ~src_mask)) && (|src_mask)) : (|(nf & src_mask));
        err_hit = |(ne & src_mask);
    end

    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        done_d        = done_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        timeout_d     = timeout_q;
        seen_finish_d = seen_finish_q;
        seen_error_d  = seen_error_q;
        cycle_count_d = cycle_count_q;
        drain_cnt_d   = drain_cnt_q;

        unique case (state_q)
            StRun: begin
                seen_finish_d = nf;
                seen_error_d  = ne;
                if (cycle_count_q != '1) begin
                    cycle_count_d = cycle_count_q + CNT_W'(1);
                end
                if (err_hit) begin
                    fail_d      = 1'b1;
                    state_d     = StDrain;
                    drain_cnt_d = '0;
                end else if (fin_ok) begin
                    state_d     = StDrain;
                    drain_cnt_d = '0;
                end else if ((TIMEOUT_CYCLES != 0) && (cycle_count_q == TIMEOUT_LAST)) begin
                    timeout_d   = 1'b1;
                    state_d     = StDrain;
                    drain_cnt_d = '0;
                end
            end
            StDrain: begin
                seen_finish_d = nf;
                seen_error_d  = ne;
                if (err_hit) begin
                    fail_d = 1'b1;
                end
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    // Use fail_d so a late error on the final drain edge still spoils pass.
                    pass_d  = ~fail_d & ~timeout_q;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                end
            end
            StDone: begin
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= StRun;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
            seen_finish_q <= '0;
            seen_error_q  <= '0;
            cycle_count_q <= '0;
            drain_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            timeout_q     <= timeout_d;
            seen_finish_q <= seen_finish_d;
            seen_error_q  <= seen_error_d;
            cycle_count_q <= cycle_count_d;
            drain_cnt_q   <= drain_cnt_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign seen_finish = seen_finish_q;
    assign seen_error  = seen_error_q;
    assign cycle_count = cycle_count_q;

`ifdef SIM_FINISH_EN
    always @(posedge sys_clk) begin
        if (done_q && !sys_rst) begin
            $display("sim_finish_controller: pass=%0b fail=%0b timeout=%0b seen_finish=%b seen_error=%b cycle_count=%0d",
                     pass_q, fail_q, timeout_q, seen_finish_q, seen_error_q, cycle_count_q);
            $finish;
        end
    end
`else
`endif

endmodule

// File: tb/tb_sim_finish_controller.sv
// Scoreboard bench for sim_finish_controller: three instances with different parameters,
// expected verdicts queued at stimulus time and checked when done rises.
module tb_sim_finish_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // A: all-of, drain 4, watchdog 100
    logic        rst_a = 1'b1;
    logic [1:0]  mask_a = '0, fin_a = '0, err_a = '0;
    logic        busy_a, done_a, pass_a, fail_a, to_a;
    logic [1:0]  sf_a, se_a;
    logic [31:0] cc_a;
    // B: any-of, drain 4, no watchdog, 4-bit counter
    logic        rst_b = 1'b1;
    logic [1:0]  mask_b = '0, fin_b = '0, err_b = '0;
    logic        busy_b, done_b, pass_b, fail_b, to_b;
    logic [1:0]  sf_b, se_b;
    logic [3:0]  cc_b;
    // C: all-of, drain 0, watchdog 100
    logic        rst_c = 1'b1;
    logic [1:0]  mask_c = '0, fin_c = '0, err_c = '0;
    logic        busy_c, done_c, pass_c, fail_c, to_c;
    logic [1:0]  sf_c, se_c;
    logic [31:0] cc_c;

    sim_finish_controller #(
        .NUM_SOURCES(2), .REQUIRE_ALL(1), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(100), .CNT_W(32)
    ) u_a (
        .sys_clk(clk), .sys_rst(rst_a), .src_mask(mask_a), .finish_req(fin_a),
        .error_req(err_a), .busy(busy_a), .done(done_a), .pass(pass_a), .fail(fail_a),
        .timeout(to_a), .seen_finish(sf_a), .seen_error(se_a), .cycle_count(cc_a)
    );

    sim_finish_controller #(
        .NUM_SOURCES(2), .REQUIRE_ALL(0), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(0), .CNT_W(4)
    ) u_b (
        .sys_clk(clk), .sys_rst(rst_b), .src_mask(mask_b), .finish_req(fin_b),
        .error_req(err_b), .busy(busy_b), .done(done_b), .pass(pass_b), .fail(fail_b),
        .timeout(to_b), .seen_finish(sf_b), .seen_error(se_b), .cycle_count(cc_b)
    );

    sim_finish_controller #(
        .NUM_SOURCES(2), .REQUIRE_ALL(1), .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(100), .CNT_W(32)
    ) u_c (
        .sys_clk(clk), .sys_rst(rst_c), .src_mask(mask_c), .finish_req(fin_c),
        .error_req(err_c), .busy(busy_c), .done(done_c), .pass(pass_c), .fail(fail_c),
        .timeout(to_c), .seen_finish(sf_c), .seen_error(se_c), .cycle_count(cc_c)
    );

    typedef struct {
        logic        pass;
        logic        fail;
        logic        to;
        logic [1:0]  sf;
        logic [1:0]  se;
        logic [31:0] cc;
        int          edge_n;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    int n_tests = 0;
    int n_fail  = 0;
    int base_a = 0, base_b = 0, base_c = 0;

    function automatic exp_t mk(input logic p, input logic f, input logic t, input logic [1:0] sf,
                                input logic [1:0] se, input int cc, input int edge_n);
        exp_t e;
        e.pass = p; e.fail = f; e.to = t; e.sf = sf; e.se = se;
        e.cc = cc; e.edge_n = edge_n;
        return e;
    endfunction

    function automatic int qsize(input int which);
        if (which == 0) return q_a.size();
        if (which == 1) return q_b.size();
        return q_c.size();
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag, input logic busy, input logic done,
                             input logic pass, input logic fail, input logic to,
                             input logic [1:0] sf, input logic [1:0] se, input logic [31:0] cc);
        chk({tag, ".busy"}, 32'(busy), 1);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".pass"}, 32'(pass), 0);
        chk({tag, ".fail"}, 32'(fail), 0);
        chk({tag, ".timeout"}, 32'(to), 0);
        chk({tag, ".seen_finish"}, 32'(sf), 0);
        chk({tag, ".seen_error"}, 32'(se), 0);
        chk({tag, ".cycle_count"}, cc, 0);
    endtask

    // Monitor: pops one expectation per rising edge of done.
    task automatic on_done(input int which, input string tag, input logic p, input logic f,
                           input logic t, input logic [1:0] sf, input logic [1:0] se,
                           input logic [31:0] cc);
        exp_t e;
        if (qsize(which) == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.unexpected_done: got done=1 at edge %0d, expected done=0", tag, cyc);
        end else begin
            if (which == 0) e = q_a.pop_front();
            else if (which == 1) e = q_b.pop_front();
            else e = q_c.pop_front();
            chk({tag, ".done_edge"}, 32'(cyc), 32'(e.edge_n));
            chk({tag, ".pass"}, 32'(p), 32'(e.pass));
            chk({tag, ".fail"}, 32'(f), 32'(e.fail));
            chk({tag, ".timeout"}, 32'(t), 32'(e.to));
            chk({tag, ".seen_finish"}, 32'(sf), 32'(e.sf));
            chk({tag, ".seen_error"}, 32'(se), 32'(e.se));
            chk({tag, ".cycle_count"}, cc, e.cc);
        end
    endtask

    initial begin
        logic pa, pb, pc;
        pa = 1'b0; pb = 1'b0; pc = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (done_a && !pa) on_done(0, "A", pass_a, fail_a, to_a, sf_a, se_a, cc_a);
            if (done_b && !pb) on_done(1, "B", pass_b, fail_b, to_b, sf_b, se_b, 32'(cc_b));
            if (done_c && !pc) on_done(2, "C", pass_c, fail_c, to_c, sf_c, se_c, cc_c);
            pa = done_a; pb = done_b; pc = done_c;
        end
    end

    // Driver runs 2 time units after the edge so the monitor always samples first.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic goto(input int t);
        while (cyc < t) step();
    endtask

    task automatic wait_q(input int which, input string tag);
        for (int i = 0; i < 300; i++) begin
            if (qsize(which) == 0) break;
            step();
        end
        if (qsize(which) != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.no_done: got done=0 after 300 cycles, expected done=1", tag);
            if (which == 0) q_a.delete();
            else if (which == 1) q_b.delete();
            else q_c.delete();
        end
    endtask

    task automatic reset_a();
        rst_a = 1'b1; step(); rst_a = 1'b0; base_a = cyc;
        chk_reset("A.reset", busy_a, done_a, pass_a, fail_a, to_a, sf_a, se_a, cc_a);
    endtask

    task automatic reset_b();
        rst_b = 1'b1; step(); rst_b = 1'b0; base_b = cyc;
        chk_reset("B.reset", busy_b, done_b, pass_b, fail_b, to_b, sf_b, se_b, 32'(cc_b));
    endtask

    task automatic reset_c();
        rst_c = 1'b1; step(); rst_c = 1'b0; base_c = cyc;
        chk_reset("C.reset", busy_c, done_c, pass_c, fail_c, to_c, sf_c, se_c, cc_c);
    endtask

    // Drive f/e so they are sampled exactly at edge n after the last reset of A.
    task automatic pulse_a(input int n, input logic [1:0] f, input logic [1:0] e);
        goto(base_a + n - 1);
        fin_a = f; err_a = e;
        step();
        fin_a = '0; err_a = '0;
    endtask

    initial begin
        step();

        // all-of completion with staggered pulses
        reset_a();
        mask_a = 2'b11;
        q_a.push_back(mk(1, 0, 0, 2'b11, 2'b00, 20, base_a + 25));
        pulse_a(10, 2'b01, 2'b00);
        pulse_a(20, 2'b10, 2'b00);
        wait_q(0, "A.all_of");

        // error beats simultaneous finish
        reset_a();
        mask_a = 2'b11;
        q_a.push_back(mk(0, 1, 0, 2'b11, 2'b01, 5, base_a + 10));
        pulse_a(3, 2'b01, 2'b00);
        pulse_a(5, 2'b10, 2'b01);
        wait_q(0, "A.err_prio");

        // error during drain
        reset_a();
        mask_a = 2'b11;
        q_a.push_back(mk(0, 1, 0, 2'b11, 2'b10, 4, base_a + 9));
        pulse_a(4, 2'b11, 2'b00);
        pulse_a(6, 2'b00, 2'b10);
        wait_q(0, "A.drain_err");

        // errors on a masked source latch but do not fail
        reset_a();
        mask_a = 2'b01;
        q_a.push_back(mk(1, 0, 0, 2'b01, 2'b10, 6, base_a + 11));
        pulse_a(2, 2'b00, 2'b10);
        pulse_a(6, 2'b01, 2'b00);
        pulse_a(8, 2'b00, 2'b10);
        wait_q(0, "A.masked_err");

        // all-zero mask never completes
        reset_a();
        mask_a = 2'b00;
        fin_a = 2'b11;
        goto(base_a + 50);
        chk("A.mask0.busy", 32'(busy_a), 1);
        chk("A.mask0.done", 32'(done_a), 0);
        chk("A.mask0.cycle_count", cc_a, 50);
        fin_a = '0;

        // reset while draining with fail set
        reset_a();
        mask_a = 2'b11;
        pulse_a(3, 2'b11, 2'b01);
        chk("A.drain.busy", 32'(busy_a), 1);
        chk("A.drain.fail", 32'(fail_a), 1);
        goto(base_a + 4);
        reset_a();
        rst_a = 1'b1;

        // any-of with only source 1 unmasked
        reset_b();
        mask_b = 2'b10;
        q_b.push_back(mk(1, 0, 0, 2'b11, 2'b00, 7, base_b + 12));
        fin_b = 2'b01;
        goto(base_b + 6);
        fin_b = 2'b11;
        step();
        fin_b = 2'b01;
        wait_q(1, "B.any_of");
        fin_b = '0;

        // saturation and disabled watchdog
        reset_b();
        mask_b = 2'b11;
        goto(base_b + 14);
        chk("B.count14", 32'(cc_b), 14);
        goto(base_b + 40);
        chk("B.sat.cycle_count", 32'(cc_b), 15);
        chk("B.sat.busy", 32'(busy_b), 1);
        goto(base_b + 10000);
        chk("B.nowd.busy", 32'(busy_b), 1);
        chk("B.nowd.done", 32'(done_b), 0);
        chk("B.nowd.cycle_count", 32'(cc_b), 15);
        rst_b = 1'b1;

        // watchdog with zero drain
        reset_c();
        mask_c = 2'b11;
        q_c.push_back(mk(0, 0, 1, 2'b00, 2'b00, 100, base_c + 101));
        goto(base_c + 100);
        chk("C.wd.timeout", 32'(to_c), 1);
        chk("C.wd.done", 32'(done_c), 0);
        chk("C.wd.busy", 32'(busy_c), 1);
        wait_q(2, "C.watchdog");
        rst_c = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no end of run, expected completion");
        $fatal(1, "bench time limit reached");
    end

endmodule
